lsu_dcache_bridge: RTL and testbench
====================================

# lsu_dcache_bridge

Memory-side responder directly downstream of the LSU. It terminates the LSU's `dcache_ports_if` load channel (request/response) and store-drain channel (write), and serialises both onto a single in-order doubleword memory bus. It is the stand-in data-cache front end until the real cache/MSHR array exists. It preserves program order between drained stores and later loads, and supports exactly one load in flight, matching the LSU's single wait-load register.

## Interface
Parameters:
- `XLEN`, 64, data and address width; memory bus is one doubleword, `XLEN/8` = 8 byte strobes
- `CNT_W`, 32, width of the performance counters

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `dcache_ports_io`  slave  `dcache_ports_if`  LSU side. Load: `load_a_valid`, `load_a_ready`, `load_a_addr`[XLEN], `load_d_valid`, `load_d_data`[XLEN]. Write: `wvalid`, `wready`, `waddr`[XLEN], `wdata`[XLEN], `wmask`[8]
- `mem_req_valid`  out  1  bus request valid
- `mem_req_ready`  in  1  bus accepts the request
- `mem_req_we`  out  1  1 = write, 0 = read
- `mem_req_addr`  out  XLEN  doubleword-aligned address (`addr & ~7`)
- `mem_req_wdata`  out  XLEN  write data; passed through unshifted, already lane-aligned by the LSU
- `mem_req_wstrb`  out  8  byte strobes; equals `wmask`; 0 for reads
- `mem_resp_valid`  in  1  response pulse: read data, or write acknowledge
- `mem_resp_rdata`  in  XLEN  read doubleword
- `nr_loads_o`  out  CNT_W  count of completed loads
- `nr_stores_o`  out  CNT_W  count of acknowledged stores

## Operation
- **Capture registers:**
  - Write buffer `wb` {addr, data, mask, pend}.
  - Read buffer `rb` {addr, pend}.
- **States:**
  - `IDLE`
  - `WR_REQ`: drive write on bus.
  - `WR_WAIT`: await ack.
  - `RD_REQ`: drive read on bus.
  - `RD_WAIT`: await data.
  - `RSP`: drive `load_d_valid`.
- **Ready signals:**
  - `wready` = `load_a_ready` = (state == `IDLE`) && !`rst`.
  - Neither ready depends on `wvalid` or `load_a_valid`, because the LSU gates its valids on the readies.
- **In `IDLE`:**
  - `wvalid` captures the write into `wb`.
  - `load_a_valid` captures the load into `rb`.
  - Both may be captured in the same cycle.
  - Next state: `WR_REQ` if a write was captured, else `RD_REQ` if a load was captured, else `IDLE`.
- **Ordering rule:** a store drained in the same cycle as a load is always performed first. The store is committed, and therefore older than the load.
- **`WR_REQ`:**
  - Drives `mem_req_valid`=1, `we`=1, aligned `wb.addr`, `wb.data`, `wstrb`=`wb.mask`.
  - On `mem_req_ready`, go to `WR_WAIT`.
- **`WR_WAIT`:**
  - On `mem_resp_valid`: clear `wb.pend` and increment `nr_stores_o`.
  - Then go to `RD_REQ` if `rb.pend`, else `IDLE`.
- **`RD_REQ`:**
  - Drives `valid`=1, `we`=0, `wstrb`=0, aligned `rb.addr`.
  - On `mem_req_ready`, go to `RD_WAIT`.
- **`RD_WAIT`:**
  - On `mem_resp_valid`, register `mem_resp_rdata` into the data register and go to `RSP`.
- **`RSP`:**
  - `load_d_valid`=1 for exactly one cycle, with `load_d_data` = the full aligned doubleword. The LSU performs byte extraction and the SQ merge.
  - Increment `nr_loads_o`, clear `rb.pend`, go to `IDLE`.
- **Request stability:** request fields are held stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- **Counters:** wrap modulo 2^CNT_W.
- **Stray responses:** `mem_resp_valid` in any state other than `WR_WAIT`/`RD_WAIT` is ignored and fires a simulation-only assertion.
- **Zero-mask writes:** a write with `wmask`=0 is still issued, with `wstrb`=0.

## Timing
- **Reset state:** while `rst`=1 at a rising edge, go to `IDLE`, clear both pend flags, and zero both counters and the data register.
- **Reset values of outputs:** all outputs are 0 during reset, including `wready` and `load_a_ready`.
- **Ready after reset:** readies assert in the first cycle with `rst`=0.
- **Reset mid-transaction:** abandons the transaction with no response. The bus owner is reset in the same cycle.
- **Load latency, minimum:**
  - Capture at edge t.
  - `mem_req_valid` during cycle t..t+1, accepted at edge t+1.
  - `mem_resp_valid` sampled at edge t+2.
  - `load_d_valid` high in cycle t+2..t+3.
  - Result: 3 edges from capture to response.
- **Store occupancy, minimum:** 3 cycles (`IDLE` capture, `WR_REQ`, `WR_WAIT`) before `IDLE` returns.
- **Combined store+load:** minimum 5 cycles to `load_d_valid`.
- **Back-pressure:** each cycle `mem_req_ready`=0 adds one cycle. Each cycle without a response adds one cycle.
- **Loads in flight:** at most one; readies are low in every non-`IDLE` state.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles -> all outputs 0; readies 1 in the first cycle after release; counters 0.
- **Single load:** load `addr`=0x1003 with memory always ready and returning 0x1122334455667788 one cycle later -> bus addr 0x1000, `we`=0, `wstrb`=0; one `load_d_valid` pulse with data 0x1122334455667788, 3 cycles after capture; `nr_loads_o`=1.
- **Single store:** store `waddr`=0x2005, `wdata`=0xAB0000000000, `wmask`=0x20 -> one write at 0x2000, `wstrb`=0x20, data unchanged; `nr_stores_o`=1 after the ack; readies back to 1 the next cycle.
- **Store and load same cycle:** store to 0x3000 and load from 0x3000 in the same cycle -> write request precedes read request on the bus; the memory model returns the stored value; `load_d_valid` arrives 5 cycles after capture.
- **Back-pressure:** `mem_req_ready` low for 4 cycles -> request fields stable throughout; load latency 7; readies low throughout.
- **Reset mid-read:** assert `rst` in `RD_WAIT` -> no `load_d_valid`; `IDLE` after release; a late `mem_resp_valid` is ignored.

Source files
------------

// File: rtl/dcache_ports_if.sv
// ---------------------------------------------------------------------------
// dcache_ports_if : LSU load request/response and store-drain channels
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dcache_ports_if #(
  parameter int XLEN = 64
);
  logic              load_a_valid;
  logic              load_a_ready;
  logic [XLEN-1:0]   load_a_addr;
  logic              load_d_valid;
  logic [XLEN-1:0]   load_d_data;
  logic              wvalid;
  logic              wready;
  logic [XLEN-1:0]   waddr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wmask;

  modport master (
    output load_a_valid, load_a_addr, wvalid, waddr, wdata, wmask,
    input  load_a_ready, load_d_valid, load_d_data, wready
  );

  modport slave (
    input  load_a_valid, load_a_addr, wvalid, waddr, wdata, wmask,
    output load_a_ready, load_d_valid, load_d_data, wready
  );
endinterface

`default_nettype wire

// File: rtl/lsu_dcache_bridge.sv
// ---------------------------------------------------------------------------
// lsu_dcache_bridge : serialises LSU loads and drained stores onto one
//                     in-order doubleword memory bus, one load in flight
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_dcache_bridge #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  dcache_ports_if.slave       dcache_ports_io,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [XLEN-1:0]     mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_resp_rdata,
  output logic [CNT_W-1:0]    nr_loads_o,
  output logic [CNT_W-1:0]    nr_stores_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(XLEN/8 - 1));

  logic [2:0]        state_q,     state_d;
  logic [XLEN-1:0]   wb_addr_q,   wb_addr_d;
  logic [XLEN-1:0]   wb_data_q,   wb_data_d;
  logic [XLEN/8-1:0] wb_mask_q,   wb_mask_d;
  logic              wb_pend_q,   wb_pend_d;
  logic [XLEN-1:0]   rb_addr_q,   rb_addr_d;
  logic              rb_pend_q,   rb_pend_d;
  logic [XLEN-1:0]   rdata_q,     rdata_d;
  logic [CNT_W-1:0]  nr_loads_q,  nr_loads_d;
  logic [CNT_W-1:0]  nr_stores_q, nr_stores_d;
  logic              ready;

  // Readies ignore the valids: the LSU already gates its valids on them.
  assign ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_mask_d   = wb_mask_q;
    wb_pend_d   = wb_pend_q;
    rb_addr_d   = rb_addr_q;
    rb_pend_d   = rb_pend_q;
    rdata_d     = rdata_q;
    nr_loads_d  = nr_loads_q;
    nr_stores_d = nr_stores_q;
    case (state_q)
      S_IDLE: begin
        if (dcache_ports_io.wvalid && ready) begin
          wb_addr_d = dcache_ports_io.waddr;
          wb_data_d = dcache_ports_io.wdata;
          wb_mask_d = dcache_ports_io.wmask;
          wb_pend_d = 1'b1;
        end
        if (dcache_ports_io.load_a_valid && ready) begin
          rb_addr_d = dcache_ports_io.load_a_addr;
          rb_pend_d = 1'b1;
        end
        // A store drained alongside a load is older, so it goes first.
        if (wb_pend_d)      state_d = S_WR_REQ;
        else if (rb_pend_d) state_d = S_RD_REQ;
      end
      S_WR_REQ: begin
        if (mem_req_ready) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_resp_valid) begin
          wb_pend_d   = 1'b0;
          nr_stores_d = nr_stores_q + CNT_W'(1);
          state_d     = rb_pend_q ? S_RD_REQ : S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (mem_req_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        nr_loads_d = nr_loads_q + CNT_W'(1);
        rb_pend_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_mask_q   <= '0;
      wb_pend_q   <= 1'b0;
      rb_addr_q   <= '0;
      rb_pend_q   <= 1'b0;
      rdata_q     <= '0;
      nr_loads_q  <= '0;
      nr_stores_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_mask_q   <= wb_mask_d;
      wb_pend_q   <= wb_pend_d;
      rb_addr_q   <= rb_addr_d;
      rb_pend_q   <= rb_pend_d;
      rdata_q     <= rdata_d;
      nr_loads_q  <= nr_loads_d;
      nr_stores_q <= nr_stores_d;
    end
  end

  // Outputs are forced low while reset is held, before state is known.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    if (!rst) begin
      if (state_q == S_WR_REQ) begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = wb_addr_q & ALIGN_MASK;
        mem_req_wdata = wb_data_q;
        mem_req_wstrb = wb_mask_q;
      end else if (state_q == S_RD_REQ) begin
        mem_req_valid = 1'b1;
        mem_req_addr  = rb_addr_q & ALIGN_MASK;
      end
    end
  end

  assign dcache_ports_io.wready       = ready;
  assign dcache_ports_io.load_a_ready = ready;
  assign dcache_ports_io.load_d_valid = !rst && (state_q == S_RSP);
  assign dcache_ports_io.load_d_data  = rst ? '0 : rdata_q;
  assign nr_loads_o                   = rst ? '0 : nr_loads_q;
  assign nr_stores_o                  = rst ? '0 : nr_stores_q;

`ifndef SYNTHESIS
  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    mem_resp_valid |-> (state_q == S_WR_WAIT || state_q == S_RD_WAIT));
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_dcache_bridge.sv
// ---------------------------------------------------------------------------
// tb_lsu_dcache_bridge : directed scoreboard bench for lsu_dcache_bridge
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dcache_bridge;
  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } bus_t;

  typedef struct packed {
    logic [63:0] data;
    int          lat;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_rdata = 64'h0;
  logic [31:0] nr_loads;
  logic [31:0] nr_stores;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cap_cyc = 0;
  int exp_loads = 0;
  int exp_stores = 0;
  int resp_delay = 0;
  int resp_cnt = 0;
  bit resp_pend = 1'b0;
  logic [63:0] resp_data = 64'h0;

  bus_t bus_q[$];
  ld_t  ld_q[$];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] bus_mem [logic [63:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_ports_if #(.XLEN(XLEN)) dc ();

  lsu_dcache_bridge #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .dcache_ports_io (dc),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_wstrb   (mem_req_wstrb),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rdata  (mem_resp_rdata),
    .nr_loads_o      (nr_loads),
    .nr_stores_o     (nr_stores)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction

  // Memory bus model: checks each presented request against the expected order.
  always @(negedge clk) begin
    if (!rst && mem_req_valid) begin
      if (bus_q.size() == 0) begin
        total++; bad++;
        $error("FAIL bus_unexpected: observed request addr=%h expected none", mem_req_addr);
      end else begin
        chk("bus_we",    64'(mem_req_we), 64'(bus_q[0].we));
        chk("bus_addr",  mem_req_addr,    bus_q[0].addr);
        chk("bus_wdata", mem_req_wdata,   bus_q[0].wdata);
        chk("bus_wstrb", 64'(mem_req_wstrb), 64'(bus_q[0].wstrb));
        if (mem_req_ready) begin
          bus_t r;
          logic [63:0] a;
          r = bus_q.pop_front();
          a = mem_req_addr;
          if (mem_req_we) begin
            bus_mem[a] = merge(bus_mem.exists(a) ? bus_mem[a] : 64'h0, mem_req_wdata, mem_req_wstrb);
            resp_data = 64'h0;
          end else begin
            resp_data = bus_mem.exists(a) ? bus_mem[a] : 64'h0;
          end
          resp_pend = 1'b1;
          resp_cnt  = resp_delay;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mem_resp_valid = 1'b0;
    if (resp_pend) begin
      if (resp_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp_data;
        resp_pend = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dc.load_d_valid) begin
      if (ld_q.size() == 0) begin
        total++; bad++;
        $error("FAIL load_d_unexpected: observed pulse data=%h expected none", dc.load_d_data);
      end else begin
        ld_t e;
        e = ld_q.pop_front();
        chk("load_data", dc.load_d_data, e.data);
        chk("load_latency", 64'(cyc - cap_cyc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input bit dw, input logic [63:0] wa, input logic [63:0] wd,
                       input logic [7:0] wm, input bit dl, input logic [63:0] la,
                       input int lat);
    logic [63:0] a;
    @(negedge clk);
    chk("wready_idle", 64'(dc.wready), 64'h1);
    chk("load_a_ready_idle", 64'(dc.load_a_ready), 64'h1);
    cap_cyc = cyc + 1;
    if (dw) begin
      dc.wvalid = 1'b1; dc.waddr = wa; dc.wdata = wd; dc.wmask = wm;
      a = wa & ~64'h7;
      bus_q.push_back('{we: 1'b1, addr: a, wdata: wd, wstrb: wm});
      ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 64'h0, wd, wm);
      exp_stores++;
    end
    if (dl) begin
      dc.load_a_valid = 1'b1; dc.load_a_addr = la;
      a = la & ~64'h7;
      bus_q.push_back('{we: 1'b0, addr: a, wdata: 64'h0, wstrb: 8'h0});
      if (lat >= 0) begin
        ld_q.push_back('{data: (ref_mem.exists(a) ? ref_mem[a] : 64'h0), lat: lat});
        exp_loads++;
      end
    end
    @(posedge clk);
    #1;
    dc.wvalid = 1'b0;
    dc.load_a_valid = 1'b0;
  endtask

  task automatic wait_idle(output int elapsed);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (dc.wready === 1'b1 && bus_q.size() == 0 && ld_q.size() == 0 && !resp_pend) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $error("FAIL idle_timeout: observed busy after 60 cycles expected idle");
    end
    elapsed = cyc - cap_cyc + 1;
    chk("nr_loads",  64'(nr_loads),  64'(exp_loads));
    chk("nr_stores", 64'(nr_stores), 64'(exp_stores));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int el;
    dc.wvalid = 1'b0; dc.waddr = '0; dc.wdata = '0; dc.wmask = '0;
    dc.load_a_valid = 1'b0; dc.load_a_addr = '0;
    bus_mem[64'h1000] = 64'h1122334455667788;
    ref_mem[64'h1000] = 64'h1122334455667788;

    // Reset held for three cycles: every output low.
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_valid", 64'(mem_req_valid), 64'h0);
      chk("rst_req_we", 64'(mem_req_we), 64'h0);
      chk("rst_req_addr", mem_req_addr, 64'h0);
      chk("rst_req_wdata", mem_req_wdata, 64'h0);
      chk("rst_req_wstrb", 64'(mem_req_wstrb), 64'h0);
      chk("rst_wready", 64'(dc.wready), 64'h0);
      chk("rst_load_a_ready", 64'(dc.load_a_ready), 64'h0);
      chk("rst_load_d_valid", 64'(dc.load_d_valid), 64'h0);
      chk("rst_load_d_data", dc.load_d_data, 64'h0);
      chk("rst_nr_loads", 64'(nr_loads), 64'h0);
      chk("rst_nr_stores", 64'(nr_stores), 64'h0);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wready", 64'(dc.wready), 64'h1);
    chk("post_rst_load_a_ready", 64'(dc.load_a_ready), 64'h1);
    chk("post_rst_nr_loads", 64'(nr_loads), 64'h0);

    // Single unaligned load.
    issue(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h1003, 3);
    wait_idle(el);

    // Single partial store, readies return after three cycles.
    issue(1'b1, 64'h2005, 64'h0000AB0000000000, 8'h20, 1'b0, 64'h0, 0);
    wait_idle(el);
    chk("store_occupancy", 64'(el), 64'd3);

    // Store and load in the same cycle to the same doubleword.
    issue(1'b1, 64'h3000, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 64'h3000, 5);
    wait_idle(el);

    // Zero-mask store is still issued and leaves memory unchanged.
    issue(1'b1, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 64'h1006, 5);
    wait_idle(el);

    // Partial-mask store merged before a later load.
    issue(1'b1, 64'h3004, 64'h0000000012345678, 8'h0F, 1'b1, 64'h3000, 5);
    wait_idle(el);

    // Back-pressure: bus not ready for four cycles.
    mem_req_ready = 1'b0;
    issue(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h2000, 7);
    repeat (4) begin
      @(negedge clk);
      chk("bp_req_valid", 64'(mem_req_valid), 64'h1);
      chk("bp_load_a_ready", 64'(dc.load_a_ready), 64'h0);
      chk("bp_wready", 64'(dc.wready), 64'h0);
      @(posedge clk);
    end
    #1; mem_req_ready = 1'b1;
    wait_idle(el);

    // Reset while waiting for read data; the late response lands during reset.
    resp_delay = 2;
    issue(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h1000, -1);
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_load_d_valid", 64'(dc.load_d_valid), 64'h0);
      chk("rst_mid_req_valid", 64'(mem_req_valid), 64'h0);
      @(posedge clk);
    end
    #1; rst = 1'b0;
    resp_delay = 0;
    exp_loads = 0;
    exp_stores = 0;
    @(negedge clk);
    chk("rst_mid_ready_after", 64'(dc.load_a_ready), 64'h1);
    chk("rst_mid_no_load", 64'(dc.load_d_valid), 64'h0);
    wait_idle(el);

    // Recovery load after the abandoned transaction.
    issue(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h3000, 3);
    wait_idle(el);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
